// File: rtl/ipml_fifo_wr_packer_16to128_pkg.sv
// Shared widths, lane ratio and configuration check for the 16-to-128 write packer.
package ipml_fifo_wr_packer_16to128_pkg;

  localparam int C_IN_WIDTH  = 16;
  localparam int C_OUT_WIDTH = 128;
  localparam int C_CNT_WIDTH = 16;
  localparam int RATIO       = C_OUT_WIDTH / C_IN_WIDTH;
  localparam int LANE_W      = $clog2(RATIO);

  // Output width must be the input width times a power of two of at least 2.
  function automatic bit pack_cfg_ok(input int in_w, input int out_w);
    int r;
    if (in_w <= 0) begin
      return 1'b0;
    end else if ((out_w % in_w) != 0) begin
      return 1'b0;
    end else begin
      r = out_w / in_w;
      return (r >= 2) && ((r & (r - 1)) == 0);
    end
  endfunction

endpackage

// File: rtl/ipml_fifo_wr_packer_16to128_if.sv
// Pixel-in / FIFO-write-out bundle of the write packer; slave is the packer side.
interface ipml_fifo_wr_packer_16to128_if
  import ipml_fifo_wr_packer_16to128_pkg::*;
#(
  parameter int IN_W  = C_IN_WIDTH,
  parameter int OUT_W = C_OUT_WIDTH,
  parameter int CNT_W = C_CNT_WIDTH
);
  logic [IN_W-1:0]  in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [OUT_W-1:0] fifo_wr_data;
  logic             fifo_wr_en;
  logic             fifo_wr_vld;
  logic             line_done;
  logic [CNT_W-1:0] line_words;

  modport slave (
    input  in_data, in_valid, in_last, fifo_wr_vld,
    output in_ready, fifo_wr_data, fifo_wr_en, line_done, line_words
  );

  modport master (
    output in_data, in_valid, in_last, fifo_wr_vld,
    input  in_ready, fifo_wr_data, fifo_wr_en, line_done, line_words
  );
endinterface

// File: rtl/ipml_pack_out_reg.sv
// Single-entry holding register with valid/ready on both sides; drain and reload may share a cycle.
module ipml_pack_out_reg
  import ipml_fifo_wr_packer_16to128_pkg::*;
#(
  parameter int W = C_OUT_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_last,
  input  logic         out_ready
);
  logic         valid_q, valid_d;
  logic         last_q, last_d;
  logic [W-1:0] data_q, data_d;

  assign in_ready  = ~valid_q | out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_last  = last_q;

  // Next state: a load wins over a drain, otherwise hold the word stable.
  always_comb begin
    valid_d = valid_q;
    last_d  = last_q;
    data_d  = data_q;
    if (in_valid & in_ready) begin
      valid_d = 1'b1;
      last_d  = in_last;
      data_d  = in_data;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Holding register state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      last_q  <= last_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: rtl/ipml_fifo_wr_packer_16to128.sv
// Packs narrow pixels little-endian into wide FIFO words; end-of-line flushes a zero-padded word.
module ipml_fifo_wr_packer_16to128
  import ipml_fifo_wr_packer_16to128_pkg::*;
#(
  parameter int c_IN_WIDTH  = C_IN_WIDTH,
  parameter int c_OUT_WIDTH = C_OUT_WIDTH,
  parameter int c_CNT_WIDTH = C_CNT_WIDTH
) (
  input logic                          wr_clk,
  input logic                          wr_rst,
  ipml_fifo_wr_packer_16to128_if.slave bus
);
  localparam int RATIO_L  = c_OUT_WIDTH / c_IN_WIDTH;
  localparam int LANE_W_L = $clog2(RATIO_L);

  if (!pack_cfg_ok(c_IN_WIDTH, c_OUT_WIDTH)) begin : g_cfg_check
    $error("c_OUT_WIDTH must be c_IN_WIDTH times a power of two >= 2");
  end

  logic [LANE_W_L-1:0]    lane_q, lane_d;
  logic [c_OUT_WIDTH-1:0] acc_q, acc_d, acc_ins_s, word_s, out_data_s;
  logic [c_CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc_s, line_words_q, line_words_d;
  logic                   line_done_q, line_done_d;
  logic                   ld_ready_s, acc_s, cmpl_s, wr_s, out_valid_s, out_last_s;

  assign bus.in_ready = ~wr_rst & ld_ready_s;
  assign acc_s        = bus.in_valid & bus.in_ready;
  assign cmpl_s       = acc_s & ((lane_q == LANE_W_L'(RATIO_L - 1)) | bus.in_last);
  assign wr_s         = out_valid_s & bus.fifo_wr_vld;
  assign cnt_inc_s    = (&cnt_q) ? cnt_q : cnt_q + c_CNT_WIDTH'(1);

  // Insert the current pixel into its lane; the outgoing word keeps only lanes up to it.
  always_comb begin
    acc_ins_s = acc_q;
    acc_ins_s[lane_q*c_IN_WIDTH +: c_IN_WIDTH] = bus.in_data;
    word_s = '0;
    for (int i = 0; i < RATIO_L; i++) begin
      if (LANE_W_L'(i) <= lane_q) begin
        word_s[i*c_IN_WIDTH +: c_IN_WIDTH] = acc_ins_s[i*c_IN_WIDTH +: c_IN_WIDTH];
      end else begin
        word_s[i*c_IN_WIDTH +: c_IN_WIDTH] = '0;
      end
    end
  end

  // Lane/accumulator advance and per-line word accounting.
  always_comb begin
    lane_d       = lane_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    line_words_d = line_words_q;
    line_done_d  = 1'b0;
    if (cmpl_s) begin
      lane_d = '0;
      acc_d  = '0;
    end else if (acc_s) begin
      lane_d = lane_q + LANE_W_L'(1);
      acc_d  = acc_ins_s;
    end else begin
      lane_d = lane_q;
    end
    if (wr_s & out_last_s) begin
      line_words_d = cnt_inc_s;
      cnt_d        = '0;
      line_done_d  = 1'b1;
    end else if (wr_s) begin
      cnt_d = cnt_inc_s;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Packer state registers.
  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      lane_q       <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      line_words_q <= '0;
      line_done_q  <= 1'b0;
    end else begin
      lane_q       <= lane_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      line_words_q <= line_words_d;
      line_done_q  <= line_done_d;
    end
  end

  ipml_pack_out_reg #(.W(c_OUT_WIDTH)) u_out_reg (
    .clk       (wr_clk),
    .rst       (wr_rst),
    .in_valid  (cmpl_s),
    .in_data   (word_s),
    .in_last   (bus.in_last),
    .in_ready  (ld_ready_s),
    .out_valid (out_valid_s),
    .out_data  (out_data_s),
    .out_last  (out_last_s),
    .out_ready (bus.fifo_wr_vld)
  );

  assign bus.fifo_wr_en   = out_valid_s;
  assign bus.fifo_wr_data = out_data_s;
  assign bus.line_done    = line_done_q;
  assign bus.line_words   = line_words_q;
endmodule
